// File: rtl/cpu_pkg.sv
// Shared definitions for the stack-CPU control path: sequencer states,
// opcode constants and operand-selector codes.
package cpu_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_READ1, ST_EXEC, ST_READ2, ST_MEM, ST_WB, ST_HALTED
  } state_t;

  localparam logic [7:0] OP_PUSH_EBP    = 8'h55;
  localparam logic [7:0] OP_POP_EBP     = 8'h5D;
  localparam logic [7:0] OP_MOV_EBP_ESP = 8'h89;
  localparam logic [7:0] OP_PUSH_IMM    = 8'h6A;
  localparam logic [7:0] OP_NOP         = 8'h90;

  localparam logic [3:0] SEL_NONE    = 4'd0;
  localparam logic [3:0] SEL_ESP     = 4'd1;
  localparam logic [3:0] SEL_EBP     = 4'd2;
  localparam logic [3:0] SEL_IMM     = 4'd3;
  localparam logic [3:0] SEL_ESP_ALT = 4'd4;
endpackage

// File: rtl/phase_sequencer_if.sv
// Request / strobe / memory-handshake bundle between the instruction
// front end (master) and the phase sequencer (slave).
interface phase_sequencer_if #(
  parameter int OPW  = 8,
  parameter int SELW = 4
);
  logic            start;
  logic [OPW-1:0]  opcode;
  logic            halt;
  logic            mem_ready;
  logic            busy;
  logic            clock_3;
  logic            clock_5;
  logic [SELW-1:0] select_1;
  logic [SELW-1:0] select_2;
  logic            mem_req;
  logic            mem_we;
  logic            instr_done;
  logic [1:0]      eip_step;
  logic            illegal_op;
  logic            halted;

  modport master (
    output start, opcode, halt, mem_ready,
    input  busy, clock_3, clock_5, select_1, select_2, mem_req, mem_we,
           instr_done, eip_step, illegal_op, halted
  );

  modport slave (
    input  start, opcode, halt, mem_ready,
    output busy, clock_3, clock_5, select_1, select_2, mem_req, mem_we,
           instr_done, eip_step, illegal_op, halted
  );
endinterface

// File: rtl/opcode_decoder.sv
// Pure combinational opcode -> control-field map; also used by the
// disassembly monitor, so it carries no state.
module opcode_decoder
  import cpu_pkg::*;
#(
  parameter int OPW  = 8,
  parameter int SELW = 4
) (
  input  logic [OPW-1:0]  opcode,
  output logic [SELW-1:0] sel1,
  output logic [SELW-1:0] sel2,
  output logic            mem,
  output logic            we,
  output logic [1:0]      len,
  output logic            illegal
);
  always_comb begin
    sel1    = SELW'(SEL_NONE);
    sel2    = SELW'(SEL_NONE);
    mem     = 1'b0;
    we      = 1'b0;
    len     = 2'd0;
    illegal = 1'b0;
    case (opcode)
      OPW'(OP_PUSH_EBP): begin
        sel1 = SELW'(SEL_ESP); sel2 = SELW'(SEL_ESP); mem = 1'b1; we = 1'b1; len = 2'd1;
      end
      OPW'(OP_POP_EBP): begin
        sel1 = SELW'(SEL_ESP); mem = 1'b1; len = 2'd1;
      end
      OPW'(OP_MOV_EBP_ESP): begin
        sel1 = SELW'(SEL_ESP_ALT); len = 2'd2;
      end
      OPW'(OP_PUSH_IMM): begin
        sel1 = SELW'(SEL_ESP); sel2 = SELW'(SEL_IMM); mem = 1'b1; we = 1'b1; len = 2'd2;
      end
      OPW'(OP_NOP): len = 2'd1;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/phase_sequencer.sv
// Moore phase controller: walks one decoded instruction through
// DECODE/READ1/EXEC/READ2/[MEM]/WB, driving selector strobes and memory handshake.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW  = 8,
  parameter int SELW = 4
) (
  input  logic              clock,
  input  logic              reset,
  phase_sequencer_if.slave  bus
);
  state_t          state, state_nxt;
  logic [OPW-1:0]  opcode_q;
  logic [SELW-1:0] sel1_q, sel2_q;
  logic            mem_q, we_q, illegal_q, in_flight;
  logic [1:0]      len_q;

  logic [SELW-1:0] d_sel1, d_sel2;
  logic            d_mem, d_we, d_illegal;
  logic [1:0]      d_len;

  opcode_decoder #(.OPW(OPW), .SELW(SELW)) u_dec (
    .opcode (opcode_q),
    .sel1   (d_sel1),
    .sel2   (d_sel2),
    .mem    (d_mem),
    .we     (d_we),
    .len    (d_len),
    .illegal(d_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      opcode_q  <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      mem_q     <= 1'b0;
      we_q      <= 1'b0;
      len_q     <= 2'd0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= (state == ST_DECODE) && d_illegal;
      if (state == ST_IDLE && bus.start && !bus.halt)
        opcode_q <= bus.opcode;
      // Decode fields are frozen here so every later output is registered.
      if (state == ST_DECODE) begin
        sel1_q <= d_sel1;
        sel2_q <= d_sel2;
        mem_q  <= d_mem;
        we_q   <= d_we;
        len_q  <= d_len;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.halt) state_nxt = ST_HALTED;
                 else if (bus.start) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = d_illegal ? ST_IDLE : ST_READ1;
      ST_READ1:  state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_READ2;
      ST_READ2:  state_nxt = mem_q ? ST_MEM : ST_WB;
      ST_MEM:    if (bus.mem_ready) state_nxt = ST_WB;
      ST_WB:     state_nxt = bus.halt ? ST_HALTED : ST_IDLE;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase

    in_flight      = (state == ST_READ1) || (state == ST_EXEC) || (state == ST_READ2) ||
                     (state == ST_MEM)   || (state == ST_WB);
    bus.busy       = (state != ST_IDLE);
    bus.halted     = (state == ST_HALTED);
    bus.select_1   = in_flight ? sel1_q : '0;
    bus.select_2   = in_flight ? sel2_q : '0;
    // A zero select code means "no operand": never strobe the selector with it.
    bus.clock_3    = (state == ST_READ1) && (sel1_q != '0);
    bus.clock_5    = (state == ST_READ2) && (sel2_q != '0);
    bus.mem_req    = (state == ST_MEM);
    bus.mem_we     = (state == ST_MEM) && we_q;
    bus.instr_done = (state == ST_WB);
    bus.eip_step   = (state == ST_WB) ? len_q : 2'd0;
    bus.illegal_op = illegal_q;
  end
endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized self-checking bench: a cycle-offset timeline model predicts
// every output of each instruction from the opcode table and memory wait count.
module tb_phase_sequencer;
  typedef struct packed {
    logic       busy, c3, c5;
    logic [3:0] s1, s2;
    logic       mreq, mwe, done;
    logic [1:0] step;
    logic       ill, hlt;
  } exp_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] s1, s2;
    logic       mem, we;
    logic [1:0] len;
  } dec_t;

  logic clock, reset;
  int   n_chk = 0, n_fail = 0;
  bit   prev_ill = 0;
  exp_t obs;

  phase_sequencer_if #(.OPW(8), .SELW(4)) bus ();
  phase_sequencer #(.OPW(8), .SELW(4)) dut (.clock(clock), .reset(reset), .bus(bus));

  assign obs = {bus.busy, bus.clock_3, bus.clock_5, bus.select_1, bus.select_2,
                bus.mem_req, bus.mem_we, bus.instr_done, bus.eip_step,
                bus.illegal_op, bus.halted};

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic dec_t tbl(input logic [7:0] op);
    case (op)
      8'h55:   return '{1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 2'd1};
      8'h5D:   return '{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 2'd1};
      8'h89:   return '{1'b1, 4'd4, 4'd0, 1'b0, 1'b0, 2'd2};
      8'h6A:   return '{1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 2'd2};
      8'h90:   return '{1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'd1};
      default: return '0;
    endcase
  endfunction

  // Expected outputs k cycles after the start-accept cycle.
  function automatic exp_t model(input logic [7:0] op, input int w, input int k);
    dec_t d = tbl(op);
    exp_t e = '0;
    int   wb = d.mem ? 6 + w : 5;
    if (k == 0) return e;
    e.busy = 1'b1;
    if (k == 1 || !d.legal) return e;
    e.s1 = d.s1;
    e.s2 = d.s2;
    if (k == 2) e.c3 = (d.s1 != 0);
    if (k == 4) e.c5 = (d.s2 != 0);
    if (d.mem && k >= 5 && k < wb) begin e.mreq = 1'b1; e.mwe = d.we; end
    if (k == wb) begin e.done = 1'b1; e.step = d.len; end
    return e;
  endfunction

  task automatic run_txn(input logic [7:0] op, input int w, input bit halt_wb, input int rst_k);
    dec_t d = tbl(op);
    exp_t e;
    int   wb = !d.legal ? 1 : (d.mem ? 6 + w : 5);
    for (int k = 0; k <= wb; k++) begin
      if (k == 0) begin
        bus.start = 1'b1; bus.opcode = op; bus.halt = 1'b0;
      end else begin
        bus.start  = halt_wb ? 1'b1 : 1'($urandom_range(0, 1));
        bus.opcode = 8'($urandom);
        bus.halt   = halt_wb ? (k >= 3) : (k == wb ? 1'b0 : 1'($urandom_range(0, 1)));
      end
      if (d.legal && d.mem && k >= 5 && k < wb) bus.mem_ready = (k == wb - 1);
      else bus.mem_ready = 1'($urandom_range(0, 1));
      e = model(op, w, k);
      if (k == 0) e.ill = prev_ill;
      chk($sformatf("op%02h_w%0d_k%0d", op, w, k), 32'(obs), 32'(e));
      if (k == rst_k) begin
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.start = 1'b0; bus.halt = 1'b0;
        chk("reset_abort", 32'(obs), 32'd0);
        prev_ill = 0;
        return;
      end
      tick();
    end
    prev_ill = !d.legal;
    bus.start = 1'b0;
    bus.halt  = 1'b0;
  endtask

  initial begin
    logic [7:0] legal_ops [5] = '{8'h55, 8'h5D, 8'h89, 8'h6A, 8'h90};
    exp_t hexp;
    logic [7:0] op;
    reset = 1'b1;
    bus.start = 1'b0; bus.opcode = '0; bus.halt = 1'b0; bus.mem_ready = 1'b0;
    tick(); tick();
    chk("reset_state", 32'(obs), 32'd0);
    reset = 1'b0;

    run_txn(8'h90, 0, 0, -1);
    run_txn(8'h55, 0, 0, -1);
    run_txn(8'h5D, 3, 0, -1);
    run_txn(8'hFF, 0, 0, -1);
    run_txn(8'h55, 1, 0, -1);   // accepted in the same cycle as the illegal_op pulse
    run_txn(8'h89, 0, 0, -1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = legal_ops[$urandom_range(0, 4)];
      run_txn(op, int'($urandom_range(0, 4)), 0, -1);
    end

    run_txn(8'h55, 3, 0, 6);    // reset during second MEM cycle
    chk("idle_after_abort", 32'(obs), 32'd0);

    run_txn(8'h6A, 0, 1, -1);
    hexp = '0; hexp.busy = 1'b1; hexp.hlt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'b1; bus.halt = 1'($urandom_range(0, 1)); bus.opcode = 8'h90;
      bus.mem_ready = 1'($urandom_range(0, 1));
      chk($sformatf("halted_%0d", i), 32'(obs), 32'(hexp));
      tick();
    end

    bus.start = 1'b0; bus.halt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_from_halted", 32'(obs), 32'd0);

    bus.start = 1'b1; bus.halt = 1'b1; bus.opcode = 8'h90;
    tick();
    bus.start = 1'b0;
    chk("halt_over_start", 32'(obs), 32'(hexp));
    tick();
    chk("halt_sticky", 32'(obs), 32'(hexp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Multi-cycle instruction phase controller for the stack-oriented CPU datapath. Accepts one decoded-opcode request at a time and steps it through fixed phases. Drives the operand-selector phase strobes (clock_3 for first operand read, clock_5 for second) and the 4-bit select codes. Handles the data-memory wait handshake and reports completion and the eip step.

Parameters:
OPW, 8, opcode width
SELW, 4, select-code width

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high
start  input  1  instruction valid; sampled only in IDLE
opcode  input  OPW  opcode, sampled with start
halt  input  1  level; stop after current instruction
mem_ready  input  1  data memory completes access this cycle
busy  output  1  high in every state except IDLE
clock_3  output  1  first-operand read strobe
clock_5  output  1  second-operand read strobe
select_1  output  SELW  first-operand select code
select_2  output  SELW  second-operand select code
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read; valid while mem_req
instr_done  output  1  one-cycle pulse in WB
eip_step  output  2  instruction length; valid while instr_done, else 0
illegal_op  output  1  one-cycle pulse on an undecodable opcode
halted  output  1  high in HALTED

Behaviour:
- Moore FSM. Every output comes from registered state or registered decode fields; no input-to-output combinational path.
- States: IDLE, DECODE, READ1, EXEC, READ2, MEM, WB, HALTED.
- Reset: state=IDLE. All outputs 0, including both select codes. Reset mid-instruction aborts at once; there is no partial writeback.
- IDLE:
  - halt=1 -> HALTED. halt takes priority over start.
  - Otherwise start=1 -> DECODE and latch opcode.
- DECODE:
  - Latch the decode fields sel1, sel2, mem, we, len.
  - Illegal opcode -> illegal_op pulse in the next cycle, then IDLE. clock_3, clock_5 and mem_req are never asserted.
  - Legal opcode -> READ1.
- Decode table, as sel1/sel2/mem/we/len:
  - 0x55 push ebp: 1/1/1/1/1
  - 0x5D pop ebp: 1/0/1/0/1
  - 0x89 mov ebp,esp: 4/0/0/0/2
  - 0x6A push imm8: 1/3/1/1/2
  - 0x90 nop: 0/0/0/0/1
  - All other opcodes are illegal.
- select_1 and select_2 are held at the latched codes from the cycle after DECODE through WB. They are 0 in IDLE and HALTED.
- clock_3 is high for exactly the one READ1 cycle, and only when sel1 != 0. clock_5 is high for exactly the one READ2 cycle, and only when sel2 != 0. The selector is never strobed with code 0.
- State path: READ1 -> EXEC -> READ2.
- READ2 -> MEM if mem=1, else -> WB.
- MEM:
  - mem_req=1 and mem_we=we for every MEM cycle.
  - Stay while mem_ready=0. mem_ready=1 -> WB on the next edge, including on the first MEM cycle.
  - mem_ready outside MEM is ignored.
- WB: instr_done=1 and eip_step=len for one cycle. Then HALTED if halt=1, else IDLE.
- start outside IDLE is ignored. There is no queueing; the requester holds start until it sees busy=0.
- HALTED is left only by reset.
- Latency with start accepted at cycle T:
  - Non-memory instruction: instr_done at T+5.
  - Memory instruction with mem_ready high: instr_done at T+6.
  - Each extra low mem_ready cycle adds 1.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding
  - opcode constants OP_PUSH_EBP, OP_POP_EBP, OP_MOV_EBP_ESP, OP_PUSH_IMM, OP_NOP
  - select codes SEL_NONE=0, SEL_ESP=1, SEL_EBP=2, SEL_IMM=3, SEL_ESP_ALT=4
- One combinational sub-module, opcode_decoder: maps opcode to {sel1, sel2, mem, we, len, illegal}. It is reused by the disassembly monitor.

Test Plan:
- Reset, then start with 0x90 at T -> busy from T+1; clock_3 and clock_5 never high; instr_done=1 and eip_step=1 at T+5; busy=0 at T+6.
- Start with 0x55, mem_ready tied 1 -> clock_3 at T+2 with select_1=1; clock_5 at T+4 with select_2=1; mem_req=1 and mem_we=1 at T+5; instr_done at T+6.
- Start with 0x5D, mem_ready low for 3 MEM cycles -> mem_req high for 4 cycles with mem_we=0; clock_5 never high; instr_done at T+9, eip_step=1.
- Start with 0xFF -> illegal_op pulse at T+2; no strobes and no mem_req; busy=0 at T+2; a new start at T+2 is accepted.
- Start 0x6A with start held high and halt raised at T+3 -> the second start is ignored while busy; eip_step=2 at T+6; HALTED from T+7; start is ignored afterward.
- Reset asserted during MEM of 0x55 -> next cycle state is IDLE; all outputs 0; select_1 and select_2 are 0.
